timer_cmd_tx: RTL and testbench

Initiator side of the serial timer-command link. On a local start request, it serialises a fixed preamble followed by a delay payload onto a one-bit data line. It then waits for the remote timer's done indication and answers with ack. It sits between the control/sequencer logic and the pattern-detecting timer block, and owns the data and ack wires of that interface.

---
 rtl/timer_cmd_tx.sv | 131 +++++++++++++
 tb/tb_timer_cmd_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_cmd_tx.sv
// Serialises {PREAMBLE, delay} MSB-first on data, then waits for done and acks it.
// First bit one cycle after start is accepted; start is only taken when ready (IDLE), ignored while busy.
module timer_cmd_tx #(
    parameter logic [3:0] PREAMBLE = 4'b1101,
    parameter int         DELAY_W  = 4,
    parameter int         TO_W     = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd20000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay,
    input  logic               done,
    output logic               data,
    output logic               ack,
    output logic               ready,
    output logic               busy,
    output logic               timeout_err
);

    localparam int FRAME_W = 4 + DELAY_W;
    localparam int MAXB    = (DELAY_W > 4) ? DELAY_W : 4;
    localparam int CNT_W   = $clog2(MAXB);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        PAY       = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               data_q, data_d;
    logic               ack_q, ack_d;
    logic               to_err_q, to_err_d;
    logic [FRAME_W-1:0] frame;

    assign frame = {PREAMBLE, delay};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        data_d    = 1'b0;
        ack_d     = 1'b0;
        to_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // The MSB goes straight to data; the register keeps the rest.
                    data_d    = frame[FRAME_W-1];
                    sr_d      = frame << 1;
                    bit_cnt_d = '0;
                    state_d   = PRE;
                end
            end
            PRE: begin
                data_d = sr_q[FRAME_W-1];
                sr_d   = sr_q << 1;
                if (bit_cnt_q == CNT_W'(3)) begin
                    bit_cnt_d = '0;
                    state_d   = PAY;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PAY: begin
                if (bit_cnt_q == CNT_W'(DELAY_W - 1)) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end else begin
                    data_d    = sr_q[FRAME_W-1];
                    sr_d      = sr_q << 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                // done beats the timeout when both land on the same edge.
                if (done) begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else if (to_cnt_q == TIMEOUT - TO_W'(1)) begin
                    to_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ACK: begin
                if (done) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            data_q    <= 1'b0;
            ack_q     <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            to_err_q  <= to_err_d;
        end
    end

    assign data        = data_q;
    assign ack         = ack_q;
    assign timeout_err = to_err_q;
    assign ready       = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Directed bench for timer_cmd_tx with hand-computed serial frames and handshakes.
module tb_timer_cmd_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] delay;
    logic       done;
    logic       data;
    logic       ack;
    logic       ready;
    logic       busy;
    logic       timeout_err;

    int vectors = 0;
    int fails   = 0;

    timer_cmd_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .delay       (delay),
        .done        (done),
        .data        (data),
        .ack         (ack),
        .ready       (ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sends one frame with start pulsed for one accepting edge; leaves the DUT in its first WAIT_DONE cycle.
    task automatic send_frame(input string tag, input logic [3:0] d, input logic [7:0] exp_bits);
        start = 1'b1;
        delay = d;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            chk({tag, "_data"}, int'(data), int'(exp_bits[7-i]));
            chk({tag, "_busy"}, int'(busy), 1);
            chk({tag, "_ready"}, int'(ready), 0);
        end
        tick();
        chk({tag, "_data_after"}, int'(data), 0);
        chk({tag, "_wait_busy"}, int'(busy), 1);
    endtask

    initial begin
        int pulses;
        int pulse_at;
        int acks;
        logic [7:0] exp2;

        reset_n = 1'b0;
        start   = 1'b0;
        delay   = 4'd0;
        done    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_to", int'(timeout_err), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        tick();
        chk("idle_data", int'(data), 0);

        // Frame 1: minimum-width ack.
        send_frame("f1", 4'b0110, 8'b1101_0110);
        done = 1'b1;
        tick();
        chk("f1_ack", int'(ack), 1);
        done = 1'b0;
        tick();
        chk("f1_ack_drop", int'(ack), 0);
        chk("f1_ready", int'(ready), 1);

        // Frame 2: done held for three cycles.
        send_frame("f2", 4'b1111, 8'b1101_1111);
        done = 1'b1;
        chk("f2_ack_pre", int'(ack), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f2_ack_hold", int'(ack), 1);
            chk("f2_ready_hold", int'(ready), 0);
        end
        done = 1'b0;
        tick();
        chk("f2_ack_end", int'(ack), 0);
        chk("f2_ready_end", int'(ready), 1);

        // Frame 3: done during the preamble is ignored, then the wait times out.
        start = 1'b1;
        delay = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            done  = (i < 3);
            exp2  = 8'b1101_0011;
            chk("f3_data", int'(data), int'(exp2[7-i]));
            chk("f3_ack", int'(ack), 0);
        end
        done = 1'b0;
        tick();
        chk("f3_wait_busy", int'(busy), 1);
        pulses   = 0;
        pulse_at = -1;
        acks     = 0;
        for (int i = 1; i <= 20000; i++) begin
            tick();
            if (timeout_err) begin
                pulses++;
                pulse_at = i;
            end
            if (ack) acks++;
        end
        chk("to_pulses", pulses, 1);
        chk("to_pulse_cycle", pulse_at, 20000);
        chk("to_no_ack", acks, 0);
        chk("to_ready", int'(ready), 1);
        tick();
        chk("to_pulse_end", int'(timeout_err), 0);

        // Frame 4: start held, delay changed mid-frame.
        start = 1'b1;
        delay = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) delay = 4'b0110;
            exp2 = 8'b1101_1001;
            chk("f4_data", int'(data), int'(exp2[7-i]));
        end
        tick();
        chk("f4_wait", int'(data), 0);
        done = 1'b1;
        tick();
        chk("f4_ack", int'(ack), 1);
        done = 1'b0;
        tick();
        chk("f4_gap_ready", int'(ready), 1);
        chk("f4_gap_data", int'(data), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp2 = 8'b1101_0110;
            chk("f5_data", int'(data), int'(exp2[7-i]));
            chk("f5_busy", int'(busy), 1);
        end
        start = 1'b0;
        tick();
        chk("f5_wait", int'(busy), 1);
        // Done arrives on the same edge the timeout would fire.
        pulses = 0;
        for (int i = 1; i < 20000; i++) begin
            tick();
            if (timeout_err) pulses++;
        end
        chk("lim_no_early_to", pulses, 0);
        done = 1'b1;
        tick();
        chk("lim_ack", int'(ack), 1);
        chk("lim_to", int'(timeout_err), 0);
        done = 1'b0;
        tick();
        chk("lim_ready", int'(ready), 1);

        // Frame 6: reset on the third payload bit.
        start = 1'b1;
        delay = 4'b1010;
        for (int i = 0; i < 7; i++) begin
            tick();
            start = 1'b0;
        end
        chk("rst6_pre_data", int'(data), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst6_data", int'(data), 0);
        chk("rst6_ack", int'(ack), 0);
        chk("rst6_ready", int'(ready), 1);
        chk("rst6_busy", int'(busy), 0);
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data || !ready) pulses++;
        end
        chk("rst6_quiet", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
